slave_port_arbiter: RTL and testbench
=====================================

Name: slave_port_arbiter

Overview:
Upstream neighbour of the crossbar slave endpoint. Takes requests from pMasters master ports and grants them with round-robin arbitration. Drives the single slave-side req/cmd/wdata interface and returns ack, rdata and error to the granted master. Handles the slave's one-cycle ack pulse, its rdata arriving one cycle after ack, its post-reset init delay, and a non-responding slave via an ack timeout.

Parameters:
pMasters, 4, number of master ports (2..8)
pAck_Timeout, 64, max cycles in REQ without slave_ack before abort; must exceed slave init delay (50)
pData_W, 32, data bus width

Ports:
iClk  input  1  clock
iRst  input  1  reset, asynchronous, active-low
m_req  input  pMasters  per-master request, held until its m_ack
m_cmd  input  pMasters  per-master op: 0 read, 1 write
m_wdata  input  pMasters*pData_W  per-master write data, master i at bits [i*pData_W +: pData_W]
m_ack  output  pMasters  one-cycle completion pulse to the granted master
m_err  output  pMasters  one-cycle timeout flag, coincident with m_ack
m_rdata  output  pData_W  shared read-data bus, valid only in the m_ack cycle
slave_req  output  1  request to slave
slave_cmd  output  1  op to slave
slave_wdata  output  pData_W  write data to slave
slave_ack  input  1  slave ack pulse
slave_rdata  input  pData_W  slave read data, valid the cycle after slave_ack
busy  output  1  high in every state except IDLE

Behaviour:
- All outputs are registered. Async reset (iRst=0) clears immediately: state=IDLE, slave_req=0, slave_cmd=0, slave_wdata=0, m_ack=0, m_err=0, m_rdata=0, busy=0, timeout counter=0, last_grant=pMasters-1 (so master 0 has first priority).
- States: IDLE, REQ, RDATA, RESP.
- IDLE:
  - If any m_req is set, pick the first requester scanning from last_grant+1 with wrap-around.
  - Latch grant index g, slave_cmd=m_cmd[g], slave_wdata=m_wdata[g]; set slave_req=1, counter=0; go to REQ.
  - Requests that arrive later are not considered until the next IDLE.
- REQ:
  - On slave_ack=1: slave_req<=0. Read goes to RDATA; write goes to RESP.
  - Otherwise counter++. If the counter reaches pAck_Timeout-1 with no ack: slave_req<=0, set the error flag, go to RESP.
  - If ack and timeout occur in the same cycle, ack wins.
- RDATA: capture slave_rdata into m_rdata; go to RESP.
- RESP:
  - m_ack[g]=1 for exactly one cycle; m_err[g]=error flag; last_grant<=g; go to IDLE.
  - On a write or a timed-out read, m_rdata holds its previous value.
- slave_req drops on the same edge that samples slave_ack, so the slave, which is back in its wait state one cycle after ack, never sees a stale req.
- Masters must drop m_req on the edge that samples m_ack. A request still asserted in IDLE is treated as a new transaction.
- Latency (T = IDLE cycle that sees m_req, slave responsive):
  - slave_req high in T+1; slave_ack in T+2.
  - Write: m_ack in T+3.
  - Read: slave_rdata valid in T+3, m_ack and m_rdata in T+4.
- While the slave is in its init delay, slave_req stays high; completion waits for the slave's ack, subject to timeout.
- m_cmd/m_wdata changes after grant are ignored (latched values are used).
- Reset mid-transaction aborts with no m_ack. The slave uses its own synchronous reset and is expected to be reset concurrently.
- Timeout counter width is $clog2(pAck_Timeout+1) bits; it never wraps.

Decomposition:
- Package xbar_pkg:
  - state enum: one-hot, IDLE/REQ/RDATA/RESP.
  - CMD_READ=1'b0, CMD_WRITE=1'b1.
  - DATA_W=32.
- Sub-module rr_picker, combinational:
  - Inputs: req vector, last_grant.
  - Outputs: grant index and valid.
  - Instantiated once.

Test Plan:
- Slave idle past init; master0 writes 0xDEADBEEF, then reads -> slave_req high exactly 1 cycle per op; write m_ack[0] at T+3; read m_ack[0] at T+4 with m_rdata=0xDEADBEEF; m_err=0.
- All 4 masters request continuously, each writing its index -> grant order 0,1,2,3,0,...; no two m_ack bits set together; final slave read returns the last writer's value.
- Master2 requests immediately after reset while the slave is in its 50-cycle init delay (pAck_Timeout=64) -> completes without error once the slave wakes.
- Slave held in reset, pAck_Timeout=8 -> slave_req drops after 8 REQ cycles; m_ack[1] and m_err[1] pulse together; arbiter returns to IDLE and serves the next request.
- iRst asserted in the REQ cycle -> slave_req, busy, m_ack go 0 immediately; after release, master0 is granted first.
- Master1 changes m_wdata to 0x1 after grant -> slave receives the value latched at grant time.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared types and constants for the crossbar slave-port arbiter.
package xbar_pkg;

  localparam int DATA_W = 32;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_REQ   = 4'b0010,
    ST_RDATA = 4'b0100,
    ST_RESP  = 4'b1000
  } state_e;

  // Index width for a vector of n entries, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slave_port_arbiter_if.sv
// Master-side and slave-side buses of the arbiter. The "slave" modport is the
// arbiter (it serves the masters); "master" is the surrounding environment.
interface slave_port_arbiter_if #(
  parameter int pMasters = 4,
  parameter int pData_W  = 32
) ();

  logic [pMasters-1:0]         m_req;
  logic [pMasters-1:0]         m_cmd;
  logic [pMasters*pData_W-1:0] m_wdata;
  logic [pMasters-1:0]         m_ack;
  logic [pMasters-1:0]         m_err;
  logic [pData_W-1:0]          m_rdata;

  logic                        slave_req;
  logic                        slave_cmd;
  logic [pData_W-1:0]          slave_wdata;
  logic                        slave_ack;
  logic [pData_W-1:0]          slave_rdata;

  logic                        busy;

  modport slave (
    input  m_req, m_cmd, m_wdata, slave_ack, slave_rdata,
    output m_ack, m_err, m_rdata, slave_req, slave_cmd, slave_wdata, busy
  );

  modport master (
    output m_req, m_cmd, m_wdata, slave_ack, slave_rdata,
    input  m_ack, m_err, m_rdata, slave_req, slave_cmd, slave_wdata, busy
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request after last_i, wrapping.
module rr_picker
  import xbar_pkg::*;
#(
  parameter  int pMasters = 4,
  localparam int IDX_W    = idx_w(pMasters)
) (
  input  logic [pMasters-1:0] req_i,
  input  logic [IDX_W-1:0]    last_i,
  output logic [IDX_W-1:0]    grant_o,
  output logic                valid_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    grant_o  = '0;
    valid_o  = |req_i;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= pMasters; k++) begin
      cand     = (int'(last_i) + k) % pMasters;
      cand_idx = IDX_W'(cand);
      if (!found && req_i[cand_idx]) begin
        grant_o = cand_idx;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/slave_port_arbiter.sv
// Round-robin arbiter in front of a single slave port: one transaction at a
// time, registered outputs, ack timeout for a slave that never answers.
module slave_port_arbiter
  import xbar_pkg::*;
#(
  parameter int pMasters     = 4,
  parameter int pAck_Timeout = 64,
  parameter int pData_W      = DATA_W
) (
  input  logic                 iClk,
  input  logic                 iRst,
  slave_port_arbiter_if.slave  bus
);

  localparam int IDX_W = idx_w(pMasters);
  localparam int CNT_W = $clog2(pAck_Timeout + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(pAck_Timeout - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_q, req_d;
  logic                cmd_q, cmd_d;
  logic [pData_W-1:0]  wdata_q, wdata_d;
  logic [pData_W-1:0]  rdata_q, rdata_d;
  logic [pMasters-1:0] mack_q, mack_d;
  logic [pMasters-1:0] merr_q, merr_d;
  logic                busy_q, busy_d;

  logic [IDX_W-1:0]    pick;
  logic                pick_vld;
  logic [pData_W-1:0]  wdata_arr [pMasters];

  for (genvar i = 0; i < pMasters; i++) begin : g_wdata
    assign wdata_arr[i] = bus.m_wdata[i*pData_W +: pData_W];
  end

  rr_picker #(.pMasters(pMasters)) u_rr_picker (
    .req_i   (bus.m_req),
    .last_i  (last_q),
    .grant_o (pick),
    .valid_o (pick_vld)
  );

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(pMasters - 1);
      cnt_q   <= '0;
      req_q   <= 1'b0;
      cmd_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      mack_q  <= '0;
      merr_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      cmd_q   <= cmd_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mack_q  <= mack_d;
      merr_q  <= merr_d;
      busy_q  <= busy_d;
    end
  end

  // m_ack/m_err are loaded on the edge entering RESP so they are visible
  // exactly during the RESP cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    cmd_d   = cmd_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mack_d  = '0;
    merr_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          cmd_d   = bus.m_cmd[pick];
          wdata_d = wdata_arr[pick];
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.slave_ack) begin
          req_d = 1'b0;
          if (cmd_q == CMD_READ) begin
            state_d = ST_RDATA;
          end else begin
            mack_d[grant_q] = 1'b1;
            state_d         = ST_RESP;
          end
        end else if (cnt_q == CNT_LAST) begin
          req_d           = 1'b0;
          mack_d[grant_q] = 1'b1;
          merr_d[grant_q] = 1'b1;
          state_d         = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RDATA: begin
        rdata_d         = bus.slave_rdata;
        mack_d[grant_q] = 1'b1;
        state_d         = ST_RESP;
      end
      ST_RESP: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.slave_req   = req_q;
  assign bus.slave_cmd   = cmd_q;
  assign bus.slave_wdata = wdata_q;
  assign bus.m_ack       = mack_q;
  assign bus.m_err       = merr_q;
  assign bus.m_rdata     = rdata_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Directed bench for slave_port_arbiter with a registered single-word slave
// model that has a 50-cycle init delay and its own synchronous reset.
module tb_slave_port_arbiter;
  import xbar_pkg::*;

  logic iClk;
  logic iRst;
  logic slave_rst;

  int n_checks = 0;
  int n_errors = 0;
  int multi    = 0;
  int ord_q[$];

  int          slv_acks = 0;
  int          init_cnt;
  logic        slv_busy;
  logic        slv_cmd;
  logic [31:0] slv_mem;

  slave_port_arbiter_if #(.pMasters(4), .pData_W(32)) bus_if ();

  slave_port_arbiter #(.pMasters(4), .pAck_Timeout(64), .pData_W(32)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus_if)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Slave: acks one cycle after it sees req, rdata one cycle after ack.
  always @(posedge iClk) begin
    if (slave_rst) begin
      bus_if.slave_ack   <= 1'b0;
      bus_if.slave_rdata <= '0;
      slv_busy           <= 1'b0;
      slv_cmd            <= 1'b0;
      slv_mem            <= '0;
      init_cnt           <= 0;
    end else begin
      bus_if.slave_ack <= 1'b0;
      if (init_cnt < 50) begin
        init_cnt <= init_cnt + 1;
      end else if (slv_busy) begin
        slv_busy <= 1'b0;
        if (slv_cmd == CMD_READ) bus_if.slave_rdata <= slv_mem;
      end else if (bus_if.slave_req) begin
        bus_if.slave_ack <= 1'b1;
        slv_busy         <= 1'b1;
        slv_cmd          <= bus_if.slave_cmd;
        slv_acks         <= slv_acks + 1;
        if (bus_if.slave_cmd == CMD_WRITE) slv_mem <= bus_if.slave_wdata;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transaction from master idx; lat counts negedges after the IDLE
  // edge that samples m_req until m_ack is seen.
  task automatic run_op(input int idx, input logic cmd, input logic [31:0] wd,
                        input int chg_at, output int lat, output logic [3:0] ackv,
                        output logic [3:0] errv, output logic [31:0] rd,
                        output int req_hi);
    @(posedge iClk); #1;
    bus_if.m_cmd[2'(idx)]            = cmd;
    bus_if.m_wdata[7'(idx*32) +: 32] = wd;
    bus_if.m_req[2'(idx)]            = 1'b1;
    @(posedge iClk);
    lat = 0; req_hi = 0; ackv = '0; errv = '0; rd = '0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge iClk);
      if (bus_if.slave_req) req_hi++;
      if (c == chg_at) bus_if.m_wdata[7'(idx*32) +: 32] = 32'h1;
      if (|bus_if.m_ack) begin
        lat  = c;
        ackv = bus_if.m_ack;
        errv = bus_if.m_err;
        rd   = bus_if.m_rdata;
        break;
      end
    end
    @(posedge iClk); #1;
    bus_if.m_req[2'(idx)] = 1'b0;
  endtask

  // Collect n ack pulses into ord_q; with hold the requests stay asserted.
  task automatic collect(input int n, input bit hold, output int got, output logic [3:0] errs);
    logic [3:0] a;
    bit         fnd;
    got = 0; errs = '0;
    for (int c = 0; c < 500 && got < n; c++) begin
      @(negedge iClk);
      a = bus_if.m_ack;
      if (|a) begin
        fnd = 1'b0;
        for (int k = 0; k < 4; k++) if (a[k] && !fnd) begin ord_q.push_back(k); fnd = 1'b1; end
        if ($countones(a) != 1) multi++;
        errs |= bus_if.m_err;
        got++;
        if (!hold) begin @(posedge iClk); #1; bus_if.m_req = bus_if.m_req & ~a; end
      end
    end
    if (hold) begin @(posedge iClk); #1; bus_if.m_req = '0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, req_hi, got, a0;
    logic [3:0]  ackv, errv, errs;
    logic [31:0] rd;

    iRst = 1'b1; slave_rst = 1'b1;
    bus_if.m_req = '0; bus_if.m_cmd = '0; bus_if.m_wdata = '0;
    #1 iRst = 1'b0;
    #2;
    chk("rst_slave_req", 32'(bus_if.slave_req), 0);
    chk("rst_busy", 32'(bus_if.busy), 0);
    chk("rst_m_ack", 32'(bus_if.m_ack), 0);
    chk("rst_m_err", 32'(bus_if.m_err), 0);
    chk("rst_m_rdata", bus_if.m_rdata, 0);
    chk("rst_slave_wdata", bus_if.slave_wdata, 0);
    repeat (3) @(posedge iClk);
    #1 iRst = 1'b1; slave_rst = 1'b0;
    repeat (60) @(posedge iClk);

    // Basic write then read from master 0 with a ready slave.
    a0 = slv_acks;
    run_op(0, CMD_WRITE, 32'hDEADBEEF, 0, lat, ackv, errv, rd, req_hi);
    chk("wr_latency", 32'(lat), 3);
    chk("wr_ack", 32'(ackv), 32'h1);
    chk("wr_err", 32'(errv), 0);
    chk("wr_slave_acks", 32'(slv_acks - a0), 1);
    chk("wr_slave_mem", slv_mem, 32'hDEADBEEF);
    run_op(0, CMD_READ, 32'h0, 0, lat, ackv, errv, rd, req_hi);
    chk("rd_latency", 32'(lat), 4);
    chk("rd_ack", 32'(ackv), 32'h1);
    chk("rd_err", 32'(errv), 0);
    chk("rd_data", rd, 32'hDEADBEEF);

    // All four masters writing continuously; last grant was master 0.
    @(posedge iClk); #1;
    bus_if.m_cmd = 4'b1111;
    for (int i = 0; i < 4; i++) bus_if.m_wdata[7'(i*32) +: 32] = 32'h100 + 32'(i);
    bus_if.m_req = 4'b1111;
    ord_q.delete();
    collect(8, 1'b1, got, errs);
    chk("rr_count", 32'(got), 8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("rr_order%0d", k), (ord_q.size() > k) ? 32'(ord_q[k]) : 32'hFF, 32'((k + 1) % 4));
    chk("rr_no_multi_ack", 32'(multi), 0);
    chk("rr_err", 32'(errs), 0);
    run_op(3, CMD_READ, 32'h0, 0, lat, ackv, errv, rd, req_hi);
    chk("rr_final_read", rd, 32'h100);
    chk("rr_final_ack", 32'(ackv), 32'h8);

    // Write data changed by master 1 after grant is ignored.
    run_op(1, CMD_WRITE, 32'hAAAA5555, 1, lat, ackv, errv, rd, req_hi);
    chk("latch_latency", 32'(lat), 3);
    chk("latch_wdata", slv_mem, 32'hAAAA5555);

    // Slave held in reset: read from master 1 times out after 64 REQ cycles.
    @(posedge iClk); #1 slave_rst = 1'b1;
    run_op(1, CMD_READ, 32'h0, 0, lat, ackv, errv, rd, req_hi);
    chk("to_req_cycles", 32'(req_hi), 64);
    chk("to_latency", 32'(lat), 65);
    chk("to_ack", 32'(ackv), 32'h2);
    chk("to_err", 32'(errv), 32'h2);
    chk("to_rdata_held", rd, 32'h100);
    chk("to_idle", 32'(bus_if.busy), 0);
    @(posedge iClk); #1 slave_rst = 1'b0;
    run_op(0, CMD_WRITE, 32'h55, 0, lat, ackv, errv, rd, req_hi);
    chk("after_to_latency", 32'(lat), 51);
    chk("after_to_ack", 32'(ackv), 32'h1);
    chk("after_to_err", 32'(errv), 0);

    // Reset while in REQ, then masters 0 and 2 request together.
    @(posedge iClk); #1;
    bus_if.m_cmd[3] = 1'b1; bus_if.m_wdata[127:96] = 32'h33; bus_if.m_req[3] = 1'b1;
    @(posedge iClk);
    @(posedge iClk); #1;
    chk("pre_rst_busy", 32'(bus_if.busy), 1);
    chk("pre_rst_slave_req", 32'(bus_if.slave_req), 1);
    iRst = 1'b0; slave_rst = 1'b1;
    #1;
    chk("mid_rst_slave_req", 32'(bus_if.slave_req), 0);
    chk("mid_rst_busy", 32'(bus_if.busy), 0);
    chk("mid_rst_m_ack", 32'(bus_if.m_ack), 0);
    bus_if.m_req = '0;
    repeat (3) @(posedge iClk);
    #1 iRst = 1'b1; slave_rst = 1'b0;
    bus_if.m_cmd = 4'b0101; bus_if.m_req = 4'b0101;
    ord_q.delete();
    collect(2, 1'b0, got, errs);
    chk("post_rst_count", 32'(got), 2);
    chk("post_rst_first", (ord_q.size() > 0) ? 32'(ord_q[0]) : 32'hFF, 0);
    chk("post_rst_second", (ord_q.size() > 1) ? 32'(ord_q[1]) : 32'hFF, 2);
    chk("post_rst_err", 32'(errs), 0);

    // Master 2 requests right after reset, during the slave init delay.
    @(posedge iClk); #1 iRst = 1'b0; slave_rst = 1'b1;
    repeat (2) @(posedge iClk);
    #1 iRst = 1'b1; slave_rst = 1'b0;
    run_op(2, CMD_WRITE, 32'h22, 0, lat, ackv, errv, rd, req_hi);
    chk("init_latency", 32'(lat), 51);
    chk("init_ack", 32'(ackv), 32'h4);
    chk("init_err", 32'(errv), 0);
    chk("init_slave_mem", slv_mem, 32'h22);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
